// File: rtl/irq_aggregator.sv
// ---------------------------------------------------------------------------
// irq_aggregator
//
// Collects N_SRC asynchronous interrupt sources, synchronises them, latches
// level- or rising-edge-triggered requests per channel and presents a single
// fixed-priority machine-external interrupt (meip) to the core. Service uses a
// claim/complete handshake: the core acknowledge claims the highest-priority
// eligible channel (lowest index) and the handler-complete pulse ends service.
//
// Parameters
//   N_SRC        number of interrupt sources (1..32)
//   SYNC_STAGES  synchroniser depth per source (>= 2)
//   ID_W         width of the claim ID ($clog2(N_SRC), minimum 1)
//
// Ports
//   clk_i          in   1      system clock, rising edge
//   reset_i        in   1      asynchronous, active-low reset
//   irq_src_i      in   N_SRC  raw interrupt sources (asynchronous)
//   irq_mask_i     in   N_SRC  1 = channel eligible for arbitration
//   irq_edge_i     in   N_SRC  1 = rising-edge mode, 0 = level mode
//   irq_ack_i      in   1      core acknowledge pulse, claims the winner
//   irq_done_i     in   1      handler-complete pulse, ends service
//   meip_o         out  1      machine-external interrupt request to the core
//   claim_valid_o  out  1      claim_id_o holds the channel in service
//   claim_id_o     out  ID_W   channel being serviced (holds after done)
//   pending_o      out  N_SRC  raw pending register
//   irq_lat_o      out  16     (IRQ_LATENCY_EN only) cycles from meip_o rise
//                              to the acknowledge, saturating at 16'hFFFF
//
// Optional feature: define IRQ_LATENCY_EN to add the request-latency counter
// and the irq_lat_o port.
// ---------------------------------------------------------------------------
module irq_aggregator #(
   parameter int N_SRC       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N_SRC-1:0] irq_src_i,
   input  logic [N_SRC-1:0] irq_mask_i,
   input  logic [N_SRC-1:0] irq_edge_i,
   input  logic             irq_ack_i,
   input  logic             irq_done_i,
   output logic             meip_o,
   output logic             claim_valid_o,
   output logic [ID_W-1:0]  claim_id_o,
   output logic [N_SRC-1:0] pending_o
`ifdef IRQ_LATENCY_EN
   ,
   output logic [15:0]      irq_lat_o
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   // Synchroniser chain: index 0 captures the raw pins, the last stage is the
   // clean synchronised level s.
   logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
   logic [N_SRC-1:0] s, s_d_q, rise;
   logic [N_SRC-1:0] pend_q, pend_set, pend_clr, elig;
   logic [ID_W-1:0]  winner;
   logic             any_elig, claim_take, done_take;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the
   // synchroniser chain into a single stage.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sync_q <= '0;
         s_d_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
         s_d_q  <= s;
      end
   end

   // Edge-mode channels set on a synchronised rising edge, level-mode
   // channels set every cycle the synchronised source is high.
   assign pend_set = (irq_edge_i & rise) | (~irq_edge_i & s);
   assign elig     = pend_q & irq_mask_i;
   assign any_elig = |elig;

   // Fixed priority: scan downwards so the lowest eligible index wins.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) winner = ID_W'(i);
      end
   end

   // A claim needs something eligible to hand out; an ack that races with
   // the last eligible channel being masked off is treated as no claim.
   assign claim_take = (state_q == REQ) && any_elig && irq_ack_i;
   assign done_take  = (state_q == SERVICE) && irq_done_i;

   always_comb begin
      pend_clr = '0;
      if (claim_take) pend_clr[winner] = 1'b1;
   end

   // Set is ORed in after the clear so a same-cycle re-trigger is not lost.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) pend_q <= '0;
      else          pend_q <= (pend_q & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_q <= IDLE;
      else          state_q <= state_nxt;
   end

   // NOTE: next-state is defaulted to the current state before the case so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (any_elig) state_nxt = REQ;
         REQ: begin
            if (!any_elig)       state_nxt = IDLE;
            else if (irq_ack_i)  state_nxt = SERVICE;
         end
         SERVICE: if (irq_done_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // claim_id holds its last value after done so software can still read it.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)        claim_id_o <= '0;
      else if (claim_take) claim_id_o <= winner;
   end

   assign meip_o        = (state_q == REQ);
   assign claim_valid_o = (state_q == SERVICE);
   assign pending_o     = pend_q;

`ifdef IRQ_LATENCY_EN
   // lat_cnt_q counts edges spent in REQ; the value reported at the ack edge
   // includes that edge, so an ack sampled k edges after meip_o rose reads k.
   logic [15:0] lat_cnt_q, lat_inc;

   assign lat_inc = (lat_cnt_q == 16'hFFFF) ? 16'hFFFF : lat_cnt_q + 16'd1;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         lat_cnt_q <= '0;
         irq_lat_o <= '0;
      end else begin
         if (state_q != REQ && state_nxt == REQ) lat_cnt_q <= '0;
         else if (state_q == REQ)                lat_cnt_q <= lat_inc;
         if (claim_take) irq_lat_o <= lat_inc;
      end
   end
`endif

endmodule
